// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus architectural register file for a 5-stage pipeline.
//   This block selects the writeback data from the MEM/WB register and commits
//   it into the register file. It provides two combinational read ports with
//   write-through bypass. It also keeps a count of committed writes and the
//   index of the most recent destination register.
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst       in   synchronous, active-high reset
//   RData     in   [DATA_W]  memory read data (MEM/WB)
//   ALU       in   [DATA_W]  ALU result (MEM/WB)
//   Mux5      in   [ADDR_W]  destination register index (MEM/WB)
//   WB        in   [2]       {RegWrite, MemtoReg}
//   RA1, RA2  in   [ADDR_W]  read port addresses
//   RD1, RD2  out  [DATA_W]  read port data (0-cycle latency, bypassed)
//   WData     out  [DATA_W]  selected writeback data
//   wcount    out  [32]      number of committed writes (wraps modulo 2**32)
//   lastDest  out  [ADDR_W]  destination index of the most recent commit
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] RData,
  input  logic [DATA_W-1:0] ALU,
  input  logic [ADDR_W-1:0] Mux5,
  input  logic [1:0]        WB,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WData,
  output logic [31:0]       wcount,
  output logic [ADDR_W-1:0] lastDest
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [31:0]       r_wcount;
  logic [ADDR_W-1:0] r_last_dest;

  logic              w_reg_write;
  logic              w_mem_to_reg;
  logic              w_commit;
  logic [DATA_W-1:0] w_wdata;

  assign w_reg_write  = WB[1];
  assign w_mem_to_reg = WB[0];

  // Register 0 is hard-wired to zero, so a write aimed at it is not a commit
  // and does not touch wcount or lastDest. Reset also suppresses the commit,
  // which disables the bypass while rst is high.
  assign w_commit = !rst && w_reg_write && (Mux5 != '0);
  assign w_wdata  = w_mem_to_reg ? RData : ALU;

  // NOTE: every signal written in an always_comb gets a default on the first
  // line. Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    RD1 = r_regs[RA1];
    RD2 = r_regs[RA2];
    if (w_commit && (RA1 == Mux5)) RD1 = w_wdata;
    if (w_commit && (RA2 == Mux5)) RD2 = w_wdata;
  end

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples pre-edge values, and simulation matches the synthesized flops.
  // NOTE: the whole array is cleared on reset because reset must zero every
  // register. This rules out a RAM macro and maps the file onto flops, which
  // is acceptable at this size.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_wcount    <= '0;
      r_last_dest <= '0;
    end else if (w_commit) begin
      r_regs[Mux5] <= w_wdata;
      r_wcount     <= r_wcount + 32'd1;
      r_last_dest  <= Mux5;
    end
  end

  assign WData    = w_wdata;
  assign wcount   = r_wcount;
  assign lastDest = r_last_dest;

endmodule
